mmcm_drp_readback: RTL and testbench
====================================

# mmcm_drp_readback

DRP read-side controller for a 7-series MMCME2/PLLE2 that fetches the counter registers of one selected output and decodes them into divide, phase-mux, delay, edge and no-count fields. It is the read/decode counterpart of the reconfiguration writer that programs those registers. It sits on the same DRP port, muxed with the writer outside this block, and lets on-chip logic or a debug path confirm the programmed clock configuration.

## Interface
- `TIMEOUT`, default 255: cycles to wait for `drp_rdy` after each `drp_en` before aborting.
- `clk`  in  1  DRP clock; all logic is on its rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `start`  in  1  request pulse; sampled only in IDLE.
- `sel`  in  4  target: 0–6 = CLKOUT0–6, 7 = CLKFBOUT, 8 = DIVCLK; 9–15 are invalid.
- `busy`  out  1  high from the accepted `start` until `valid` or `error`.
- `valid`  out  1  one-cycle pulse when the decoded fields are updated.
- `error`  out  1  one-cycle pulse on timeout or invalid `sel`.
- `divide`  out  8  effective divide, 1–128.
- `phase_mux`  out  3  Reg1[15:13]; 0 for DIVCLK.
- `delay`  out  6  Reg2[5:0]; 0 for DIVCLK.
- `edge`  out  1  edge bit.
- `no_count`  out  1  no-count bit.
- `drp_addr`  out  7  DRP address.
- `drp_en`  out  1  DRP enable; one-cycle strobe per read.
- `drp_we`  out  1  held at 0.
- `drp_di`  out  16  held at 0.
- `drp_do`  in  16  DRP read data.
- `drp_rdy`  in  1  DRP ready.

## Operation
- **Address map (Reg1/Reg2):**
  - CLKOUT0 0x08/0x09, CLKOUT1 0x0A/0x0B, CLKOUT2 0x0C/0x0D, CLKOUT3 0x0E/0x0F.
  - CLKOUT4 0x10/0x11, CLKOUT5 0x06/0x07, CLKOUT6 0x12/0x13, CLKFBOUT 0x14/0x15.
  - DIVCLK uses the single register 0x16.
- **States:** IDLE, RD1, WAIT1, RD2, WAIT2, DECODE.
- **IDLE:**
  - `start` with valid `sel`: latch `sel` → RD1.
  - `start` with `sel` > 8: pulse `error`, stay in IDLE, no DRP access.
  - `start` while not in IDLE: ignored.
- **RD1:** drive `drp_addr` = Reg1 address and `drp_en` = 1 for exactly one cycle → WAIT1.
- **WAIT1:**
  - On `drp_rdy`: capture `drp_do` into r1.
  - DIVCLK → DECODE; otherwise → RD2.
- **RD2 / WAIT2:** same as RD1/WAIT1 using the Reg2 address, capturing into r2 → DECODE.
- **Timeout:** each WAIT state runs a counter cleared on entry. When it reaches `TIMEOUT` with no `drp_rdy`, pulse `error`, return to IDLE and leave the outputs unchanged.
- **Decode for CLKOUTn/CLKFBOUT:**
  - hi = r1[11:6], lo = r1[5:0]; a field value of 0 means 64.
  - `no_count` = r2[6], `edge` = r2[7], `phase_mux` = r1[15:13], `delay` = r2[5:0].
  - `divide` = 1 if `no_count`, else hi + lo computed in 8 bits (range 2–128).
- **Decode for DIVCLK:**
  - hi = r1[11:6], lo = r1[5:0], `no_count` = r1[12], `edge` = r1[13].
  - `phase_mux` = 0, `delay` = 0; same `divide` rule as above.
- **DECODE:** register all fields, pulse `valid` → IDLE.
- `drp_rdy` arriving outside a WAIT state is ignored.
- Fields hold their values until the next `valid`.

## Timing
- **Reset:** all outputs 0, including `drp_addr`, `divide`, `busy`, `valid` and `error`; state returns to IDLE.
- **Reset mid-transaction:** abort immediately with outputs at reset values. A late `drp_rdy` after reset is ignored.
- **Latency:** `start` sampled at cycle 0, `drp_en` at cycle 1, and WAIT is entered at cycle 2.
  - With `drp_rdy` N cycles after `drp_en` (N ≥ 1), Reg1 data is captured at cycle 1+N.
  - Two-register read: `drp_en` #2 one cycle after capture; `valid` at cycle 2N+4.
  - DIVCLK: `valid` at cycle N+2.
- `busy` rises the cycle after the accepted `start` and falls in the same cycle as `valid` or `error`.
- `drp_addr` is held stable from `drp_en` until the matching `drp_rdy`.
- At most one outstanding DRP read at any time.
- Timeout `error` fires exactly `TIMEOUT` cycles after WAIT entry.

## Test plan
- **Even divide:** `sel`=0, responder returns 0x0008→0x028A and 0x0009→0x0000 with a 3-cycle `drp_rdy` latency → `divide`=20, `edge`=0, `no_count`=0; `valid` at cycle 10; exactly two `drp_en` pulses, at addresses 0x08 then 0x09.
- **Odd divide with phase fields:** `sel`=5, Reg1 0x0006=0x2083, Reg2 0x0007=0x0085 → `divide`=5, `edge`=1, `phase_mux`=1, `delay`=5.
- **No-count and all-zero fields:**
  - `sel`=7, Reg1 0x1041, Reg2 0x0040 → `divide`=1, `no_count`=1.
  - `sel`=2, Reg1 0x0000, Reg2 0x0000 → `divide`=128.
- **DIVCLK:** `sel`=8, 0x0016=0x1000 → single read, `divide`=1, `no_count`=1, `valid` at cycle N+2.
- **Errors:**
  - `sel`=9 → `error` pulse, no `drp_en`.
  - `TIMEOUT`=16 with no `drp_rdy` → `error` exactly 16 cycles after WAIT1 entry, prior fields unchanged.
- **Reset:** deassert `rst_n` during WAIT2, then return a late `drp_rdy` → all outputs 0, no `valid`; the next `start` completes normally.

Source files
------------

// File: rtl/mmcm_drp_readback.sv
`default_nettype none
// ============================================================================
// Module   : mmcm_drp_readback
// Purpose  : DRP read-side controller for a 7-series MMCME2/PLLE2. It fetches
//            the counter registers of one selected clock output and decodes
//            them into divide, phase-mux, delay, edge and no-count fields so
//            the programmed clock configuration can be confirmed on chip.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   TIMEOUT    cycles to wait for drp_rdy after each drp_en before aborting
// Ports
//   clk        DRP clock, all logic on the rising edge
//   rst_n      asynchronous active-low reset
//   start      request pulse, sampled only while idle
//   sel        target: 0-6 CLKOUT0-6, 7 CLKFBOUT, 8 DIVCLK, 9-15 invalid
//   busy       high from the accepted start until valid or error
//   valid      one-cycle pulse when the decoded fields are updated
//   error      one-cycle pulse on timeout or invalid sel
//   divide     effective divide, 1-128
//   phase_mux  Reg1[15:13] (0 for DIVCLK)
//   delay      Reg2[5:0] (0 for DIVCLK)
//   edge_bit   counter edge bit
//   no_count   counter no-count bit
//   drp_addr   DRP address
//   drp_en     DRP enable, one-cycle strobe per read
//   drp_we     DRP write enable, held low
//   drp_di     DRP write data, held at zero
//   drp_do     DRP read data
//   drp_rdy    DRP ready
// ============================================================================
module mmcm_drp_readback #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [3:0]  sel,
  output logic        busy,
  output logic        valid,
  output logic        error,
  output logic [7:0]  divide,
  output logic [2:0]  phase_mux,
  output logic [5:0]  delay,
  output logic        edge_bit,
  output logic        no_count,
  output logic [6:0]  drp_addr,
  output logic        drp_en,
  output logic        drp_we,
  output logic [15:0] drp_di,
  input  logic [15:0] drp_do,
  input  logic        drp_rdy
);

  localparam int         CNT_W      = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [3:0] SEL_DIVCLK = 4'd8;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RD1    = 3'd1,
    S_WAIT1  = 3'd2,
    S_RD2    = 3'd3,
    S_WAIT2  = 3'd4,
    S_DECODE = 3'd5
  } state_t;

  state_t           state;
  state_t           state_nx;

  logic [3:0]       sel_q;
  logic [15:0]      r1;
  logic [7:0]       r2;
  logic [CNT_W-1:0] wait_cnt;

  logic             sel_ok;
  logic             is_divclk;
  logic             in_wait;
  logic             timeout_hit;
  logic             timeout_err;
  logic             publish;
  logic [6:0]       reg1_a;
  logic [6:0]       reg2_a;

  logic [15:0]      d1;
  logic [7:0]       dec_divide;
  logic [2:0]       dec_phase_mux;
  logic [5:0]       dec_delay;
  logic             dec_edge;
  logic             dec_no_count;

  // Reg1 address of each counter; Reg2 always sits at the next address.
  function automatic logic [6:0] reg1_addr(input logic [3:0] s);
    case (s)
      4'd0:    reg1_addr = 7'h08;
      4'd1:    reg1_addr = 7'h0A;
      4'd2:    reg1_addr = 7'h0C;
      4'd3:    reg1_addr = 7'h0E;
      4'd4:    reg1_addr = 7'h10;
      4'd5:    reg1_addr = 7'h06;
      4'd6:    reg1_addr = 7'h12;
      4'd7:    reg1_addr = 7'h14;
      4'd8:    reg1_addr = 7'h16;
      default: reg1_addr = 7'h00;
    endcase
  endfunction

  // A high/low time field of zero encodes 64 cycles.
  function automatic logic [7:0] span(input logic [5:0] f);
    span = (f == 6'd0) ? 8'd64 : {2'b00, f};
  endfunction

  assign sel_ok      = (sel <= SEL_DIVCLK);
  assign is_divclk   = (sel_q == SEL_DIVCLK);
  assign reg1_a      = reg1_addr(sel_q);
  assign reg2_a      = reg1_a + 7'd1;
  assign in_wait     = (state == S_WAIT1) || (state == S_WAIT2);
  assign timeout_hit = (wait_cnt == CNT_W'(TIMEOUT - 1));
  assign timeout_err = in_wait && !drp_rdy && timeout_hit;

  // DIVCLK has no second register, so its fields are published straight off
  // the read data on the capture edge; two-register counters publish from
  // the captured r1/r2 while in DECODE.
  assign publish = ((state == S_WAIT1) && drp_rdy && is_divclk) ||
                   ((state == S_DECODE) && !is_divclk);

  assign d1 = (state == S_WAIT1) ? drp_do : r1;

  always_comb begin
    dec_no_count  = is_divclk ? d1[12] : r2[6];
    dec_edge      = is_divclk ? d1[13] : r2[7];
    dec_phase_mux = is_divclk ? 3'd0   : d1[15:13];
    dec_delay     = is_divclk ? 6'd0   : r2[5:0];
    dec_divide    = dec_no_count ? 8'd1 : (span(d1[11:6]) + span(d1[5:0]));
  end

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // --------------------------------------------------------------------------
  // Next state and DRP strobes. The address is held for the whole WAIT so it
  // stays stable from drp_en until the matching drp_rdy.
  // --------------------------------------------------------------------------
  always_comb begin
    state_nx = state;
    drp_en   = 1'b0;
    drp_addr = 7'h00;
    case (state)
      S_IDLE: begin
        if (start && sel_ok) begin
          state_nx = S_RD1;
        end
      end
      S_RD1: begin
        drp_en   = 1'b1;
        drp_addr = reg1_a;
        state_nx = S_WAIT1;
      end
      S_WAIT1: begin
        drp_addr = reg1_a;
        if (drp_rdy) begin
          state_nx = is_divclk ? S_DECODE : S_RD2;
        end else if (timeout_hit) begin
          state_nx = S_IDLE;
        end
      end
      S_RD2: begin
        drp_en   = 1'b1;
        drp_addr = reg2_a;
        state_nx = S_WAIT2;
      end
      S_WAIT2: begin
        drp_addr = reg2_a;
        if (drp_rdy) begin
          state_nx = S_DECODE;
        end else if (timeout_hit) begin
          state_nx = S_IDLE;
        end
      end
      S_DECODE: begin
        state_nx = S_IDLE;
      end
      default: begin
        state_nx = S_IDLE;
      end
    endcase
  end

  assign drp_we = 1'b0;
  assign drp_di = 16'h0000;

  // --------------------------------------------------------------------------
  // Datapath: target latch, wait counter, read capture and field registers.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_q     <= 4'd0;
      r1        <= 16'h0000;
      r2        <= 8'h00;
      wait_cnt  <= '0;
      busy      <= 1'b0;
      valid     <= 1'b0;
      error     <= 1'b0;
      divide    <= 8'd0;
      phase_mux <= 3'd0;
      delay     <= 6'd0;
      edge_bit  <= 1'b0;
      no_count  <= 1'b0;
    end else begin
      valid <= 1'b0;
      error <= 1'b0;

      if ((state == S_IDLE) && start) begin
        if (sel_ok) begin
          sel_q <= sel;
          busy  <= 1'b1;
        end else begin
          error <= 1'b1;
        end
      end

      // The RD state always precedes a WAIT, so clearing here means the
      // counter starts from zero on every WAIT entry.
      if ((state == S_RD1) || (state == S_RD2)) begin
        wait_cnt <= '0;
      end else if (in_wait) begin
        wait_cnt <= wait_cnt + CNT_W'(1);
      end

      if ((state == S_WAIT1) && drp_rdy) begin
        r1 <= drp_do;
      end
      if ((state == S_WAIT2) && drp_rdy) begin
        r2 <= drp_do[7:0];
      end

      if (publish) begin
        valid     <= 1'b1;
        busy      <= 1'b0;
        divide    <= dec_divide;
        phase_mux <= dec_phase_mux;
        delay     <= dec_delay;
        edge_bit  <= dec_edge;
        no_count  <= dec_no_count;
      end

      // Fields are deliberately left untouched on an abort.
      if (timeout_err) begin
        error <= 1'b1;
        busy  <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mmcm_drp_readback.sv
`default_nettype none
// ============================================================================
// Module   : tb_mmcm_drp_readback
// Purpose  : Self-checking bench for mmcm_drp_readback. A DRP responder model
//            answers reads from a register array after a programmable
//            latency; each directed step pushes its expected result into a
//            scoreboard that is popped when the DUT pulses valid or error.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mmcm_drp_readback;

  localparam int TMO = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  sel = 4'd0;
  logic        busy;
  logic        valid;
  logic        error;
  logic [7:0]  divide;
  logic [2:0]  phase_mux;
  logic [5:0]  delay;
  logic        edge_bit;
  logic        no_count;
  logic [6:0]  drp_addr;
  logic        drp_en;
  logic        drp_we;
  logic [15:0] drp_di;
  logic [15:0] drp_do = 16'h0000;
  logic        drp_rdy = 1'b0;

  always #5 clk = ~clk;

  mmcm_drp_readback #(.TIMEOUT(TMO)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .sel       (sel),
    .busy      (busy),
    .valid     (valid),
    .error     (error),
    .divide    (divide),
    .phase_mux (phase_mux),
    .delay     (delay),
    .edge_bit  (edge_bit),
    .no_count  (no_count),
    .drp_addr  (drp_addr),
    .drp_en    (drp_en),
    .drp_we    (drp_we),
    .drp_di    (drp_di),
    .drp_do    (drp_do),
    .drp_rdy   (drp_rdy)
  );

  typedef struct {
    bit         is_err;
    logic [7:0] div;
    logic [2:0] pm;
    logic [5:0] dly;
    logic       eb;
    logic       nc;
    int         lat;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;

  // ---------------- DRP responder model ----------------
  logic [15:0] mem [0:127];
  int          rsp_lat = 3;
  bit          rsp_on = 1'b1;
  int          rsp_cnt = 0;
  logic [6:0]  rsp_addr = 7'h00;
  bit          rsp_stale = 1'b0;
  logic [6:0]  en_log[$];
  int          overlap_cnt = 0;
  int          port_bad = 0;

  always @(negedge clk) begin
    drp_rdy = 1'b0;
    if (!rst_n) rsp_stale = 1'b1;
    if (rsp_cnt > 0) begin
      rsp_cnt = rsp_cnt - 1;
      if (rsp_cnt == 0) begin
        drp_rdy = 1'b1;
        drp_do  = mem[rsp_addr];
        if (!rsp_stale && (drp_addr !== rsp_addr)) port_bad = port_bad + 1;
      end
    end
    if (drp_en === 1'b1) begin
      if (rsp_cnt > 0) overlap_cnt = overlap_cnt + 1;
      en_log.push_back(drp_addr);
      if ((drp_we !== 1'b0) || (drp_di !== 16'h0000)) port_bad = port_bad + 1;
      if (rsp_on) begin
        rsp_cnt   = rsp_lat;
        rsp_addr  = drp_addr;
        rsp_stale = 1'b0;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors = vectors + 1;
    assert (obs === exp) else begin
      miscompares = miscompares + 1;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t mk(input bit is_err, input logic [7:0] div, input logic [2:0] pm,
                              input logic [5:0] dly, input logic eb, input logic nc, input int lat);
    exp_t e;
    e.is_err = is_err; e.div = div; e.pm = pm; e.dly = dly; e.eb = eb; e.nc = nc; e.lat = lat;
    return e;
  endfunction

  // One request: drive start, wait (bounded) for valid/error, pop and compare.
  task automatic run_read(input string tid, input logic [3:0] s, input int lat, input exp_t e,
                          input int n_en, input logic [6:0] a1, input logic [6:0] a2);
    int   rel;
    bit   seen;
    exp_t x;
    rsp_lat = lat;
    en_log.delete();
    sb.push_back(e);
    @(negedge clk);
    start = 1'b1;
    sel   = s;
    @(negedge clk);
    start = 1'b0;
    sel   = 4'd0;
    rel   = 1;
    check({tid, ".busy_rise"}, {31'd0, busy}, {31'd0, (s <= 4'd8)});
    while (!(valid === 1'b1 || error === 1'b1) && rel < 400) begin
      @(negedge clk);
      rel = rel + 1;
    end
    seen = (valid === 1'b1) || (error === 1'b1);
    check({tid, ".done_seen"}, {31'd0, seen}, 32'd1);
    if (sb.size() > 0) begin
      x = sb.pop_front();
      check({tid, ".latency"}, rel, x.lat);
      check({tid, ".valid"}, {31'd0, valid}, {31'd0, !x.is_err});
      check({tid, ".error"}, {31'd0, error}, {31'd0, x.is_err});
      check({tid, ".busy_fall"}, {31'd0, busy}, 32'd0);
      check({tid, ".divide"}, {24'd0, divide}, {24'd0, x.div});
      check({tid, ".phase_mux"}, {29'd0, phase_mux}, {29'd0, x.pm});
      check({tid, ".delay"}, {26'd0, delay}, {26'd0, x.dly});
      check({tid, ".edge"}, {31'd0, edge_bit}, {31'd0, x.eb});
      check({tid, ".no_count"}, {31'd0, no_count}, {31'd0, x.nc});
    end
    check({tid, ".en_count"}, en_log.size(), n_en);
    if (n_en >= 1 && en_log.size() >= 1) check({tid, ".addr1"}, {25'd0, en_log[0]}, {25'd0, a1});
    if (n_en >= 2 && en_log.size() >= 2) check({tid, ".addr2"}, {25'd0, en_log[1]}, {25'd0, a2});
    @(negedge clk);
    check({tid, ".pulse_end"}, {31'd0, valid | error}, 32'd0);
    check({tid, ".overlap"}, overlap_cnt, 0);
    check({tid, ".port"}, port_bad, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int rel;
    int stray;
    for (int i = 0; i < 128; i++) mem[i] = 16'h0000;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst.busy", {31'd0, busy}, 32'd0);
    check("rst.valid", {31'd0, valid}, 32'd0);
    check("rst.error", {31'd0, error}, 32'd0);
    check("rst.divide", {24'd0, divide}, 32'd0);
    check("rst.drp_addr", {25'd0, drp_addr}, 32'd0);
    check("rst.drp_en", {31'd0, drp_en}, 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Even divide: hi=10 lo=10
    mem[7'h08] = 16'h028A; mem[7'h09] = 16'h0000;
    run_read("even", 4'd0, 3, mk(0, 8'd20, 3'd0, 6'd0, 1'b0, 1'b0, 10), 2, 7'h08, 7'h09);

    // Odd divide with phase fields
    mem[7'h06] = 16'h2083; mem[7'h07] = 16'h0085;
    run_read("odd", 4'd5, 2, mk(0, 8'd5, 3'd1, 6'd5, 1'b1, 1'b0, 8), 2, 7'h06, 7'h07);

    // No-count
    mem[7'h14] = 16'h1041; mem[7'h15] = 16'h0040;
    run_read("nocnt", 4'd7, 1, mk(0, 8'd1, 3'd0, 6'd0, 1'b0, 1'b1, 6), 2, 7'h14, 7'h15);

    // All-zero fields -> 64 + 64
    mem[7'h0C] = 16'h0000; mem[7'h0D] = 16'h0000;
    run_read("zero", 4'd2, 4, mk(0, 8'd128, 3'd0, 6'd0, 1'b0, 1'b0, 12), 2, 7'h0C, 7'h0D);

    // Mixed fields: hi=3 lo=7, phase 7, delay 63
    mem[7'h12] = 16'hE0C7; mem[7'h13] = 16'h00BF;
    run_read("mixed", 4'd6, 2, mk(0, 8'd10, 3'd7, 6'd63, 1'b1, 1'b0, 8), 2, 7'h12, 7'h13);

    // One zero field: hi=0 (64) + lo=5
    mem[7'h10] = 16'h0005; mem[7'h11] = 16'h0000;
    run_read("hizero", 4'd4, 1, mk(0, 8'd69, 3'd0, 6'd0, 1'b0, 1'b0, 6), 2, 7'h10, 7'h11);

    // DIVCLK single read, valid at N+2
    mem[7'h16] = 16'h1000;
    run_read("divclk", 4'd8, 3, mk(0, 8'd1, 3'd0, 6'd0, 1'b0, 1'b1, 5), 1, 7'h16, 7'h00);

    // Restore non-trivial fields so the error cases prove they are retained
    run_read("hizero2", 4'd4, 1, mk(0, 8'd69, 3'd0, 6'd0, 1'b0, 1'b0, 6), 2, 7'h10, 7'h11);

    // Invalid sel: error next cycle, no DRP access, fields kept
    run_read("badsel", 4'd9, 3, mk(1, 8'd69, 3'd0, 6'd0, 1'b0, 1'b0, 1), 0, 7'h00, 7'h00);

    // Timeout: error TMO cycles after WAIT1 entry (cycle 2)
    rsp_on = 1'b0;
    run_read("timeout", 4'd3, 3, mk(1, 8'd69, 3'd0, 6'd0, 1'b0, 1'b0, 2 + TMO), 1, 7'h0E, 7'h00);
    rsp_on = 1'b1;

    // Reset during WAIT2 (latency 5: WAIT2 spans cycles 8..12), late drp_rdy
    mem[7'h0A] = 16'h0042; mem[7'h0B] = 16'h0000;
    rsp_lat = 5;
    @(negedge clk);
    start = 1'b1;
    sel   = 4'd1;
    @(negedge clk);
    start = 1'b0;
    sel   = 4'd0;
    rel   = 1;
    while (rel < 9) begin
      @(negedge clk);
      rel = rel + 1;
    end
    check("rstmid.in_wait2", {25'd0, drp_addr}, 32'h0B);
    rst_n = 1'b0;
    @(negedge clk);
    check("rstmid.busy", {31'd0, busy}, 32'd0);
    check("rstmid.divide", {24'd0, divide}, 32'd0);
    check("rstmid.drp_addr", {25'd0, drp_addr}, 32'd0);
    check("rstmid.drp_en", {31'd0, drp_en}, 32'd0);
    check("rstmid.fields", {20'd0, phase_mux, delay, edge_bit, no_count, valid, error}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    stray = 0;
    repeat (8) begin
      @(negedge clk);
      if (valid === 1'b1 || error === 1'b1 || busy === 1'b1) stray = stray + 1;
    end
    check("rstmid.no_valid", stray, 0);
    check("rstmid.divide_after", {24'd0, divide}, 32'd0);

    // Next start completes normally: hi=1 lo=2
    run_read("after_rst", 4'd1, 3, mk(0, 8'd3, 3'd1 & 3'd0, 6'd0, 1'b0, 1'b0, 10), 2, 7'h0A, 7'h0B);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
